adc_capture_ctrl: RTL and testbench
===================================

# adc_capture_ctrl

Triggered capture controller that writes the ADC sample stream into the circular sample RAM read by the Wishbone readout slave. It sits between the sample source, which has already been moved into the wb_clk_i domain with a valid strobe, and the RAM write port. It provides arm/trigger control with pre-trigger and post-trigger depth, then freezes the buffer. It reports the oldest-sample and trigger addresses so the readout slave can present a time-ordered record.

## Interface
Parameters:
- SAMPLE_WIDTH, 16, sample width in bits; samples are signed two's complement
- PTR_BITS, 11, RAM address width; buffer depth is DEPTH = 2^PTR_BITS

Ports:
- wb_clk_i  in  1  clock; all logic runs on its rising edge
- wb_rst_i  in  1  reset, asynchronous, active-high
- s_valid  in  1  one sample is presented this cycle
- s_data  in  SAMPLE_WIDTH  sample value
- arm  in  1  single-cycle pulse that starts a new capture
- sw_trig  in  1  single-cycle software trigger pulse
- trig_en  in  1  enables level trigger
- trig_rising  in  1  1 selects rising-edge crossing, 0 selects falling-edge crossing
- trig_level  in  SAMPLE_WIDTH  signed threshold
- pre_count  in  PTR_BITS  minimum number of samples written before the trigger is honoured; latched on arm
- post_count  in  PTR_BITS  number of samples written after the trigger sample; latched on arm
- ram_we  out  1  RAM write enable
- ram_addr  out  PTR_BITS  RAM write address
- ram_data  out  SAMPLE_WIDTH  RAM write data
- busy  out  1  high in PRE, ARMED and POST
- done  out  1  capture complete; buffer frozen
- wrapped  out  1  at least DEPTH samples were written since arm
- trig_ptr  out  PTR_BITS  RAM address of the trigger sample
- start_ptr  out  PTR_BITS  RAM address of the oldest valid sample

## Operation
- States: IDLE, PRE, ARMED, POST, DONE. Reset places the block in IDLE.
- Reset values: all outputs are 0. Internal state is also cleared: wr_ptr, written count, prev-sample valid flag, and the pending software trigger.
- IDLE / DONE: incoming samples are discarded and ram_we stays 0.
- arm, from any state:
  - latch pre_count and post_count
  - set wr_ptr to 0 and the written count to 0
  - clear done, wrapped, the prev-valid flag and the pending software trigger
  - go to PRE, or straight to ARMED if pre_count is 0
  - arm during PRE, ARMED or POST aborts the current capture and restarts it.
- Every accepted sample (s_valid high in PRE, ARMED or POST) is written to wr_ptr. wr_ptr then increments modulo DEPTH, so wrap-around is natural. The written count saturates at DEPTH; wrapped is set when it reaches DEPTH.
- PRE → ARMED: after pre_count samples have been written.
- Level trigger, ARMED only, when trig_en=1 and prev-valid=1:
  - rising fires when prev < trig_level and cur >= trig_level
  - falling fires when prev > trig_level and cur <= trig_level
  - comparisons are signed, full width
  - the first sample after arm never fires a level trigger.
- sw_trig pulse in PRE or ARMED sets a pending flag. The next accepted sample then fires, bypassing the pre_count requirement. sw_trig is ignored in IDLE, POST and DONE.
- Trigger fire:
  - the firing sample is still written
  - trig_ptr takes that sample's address
  - the post counter loads post_count
  - go to POST, or straight to DONE if post_count is 0.
- POST: each accepted sample decrements the post counter; when it reaches 0 after a write, go to DONE.
- Entering DONE:
  - done=1, busy=0
  - start_ptr = wr_ptr (the next write address) if wrapped=1, else 0.
- Samples older than start_ptr are overwritten when pre-trigger plus post-trigger history exceeds DEPTH; no error flag is raised.

## Timing
- Sample accepted in cycle N → ram_we=1 with ram_addr/ram_data valid in cycle N+1, single cycle.
- Trigger decision is made on the cycle N sample; trig_ptr is updated in cycle N+1.
- busy/done change in the cycle after the write that causes the state change. For the final POST write, done=1 in the same cycle that ram_we=1 for that sample.
- Throughput: one sample per cycle; s_valid may be high continuously. There is no back-pressure.
- arm coincident with s_valid: arm wins. That sample is discarded and capture starts with the next sample.
- arm coincident with sw_trig: arm wins and sw_trig is dropped.
- Asynchronous reset mid-capture:
  - ram_we drops immediately
  - the state returns to IDLE
  - RAM contents are undefined to the reader.

## Test plan
- Reset while streaming a ramp → all outputs 0, no ram_we, state IDLE until arm.
- pre_count=4, post_count=3, trig_rising=1, trig_level=100, samples 0,10,…,150 → trigger on sample 100 at addr 10. trig_ptr=10, writes at addrs 0..13, done after addr 13, wrapped=0, start_ptr=0.
- Same stream with trig_level=20, pre_count=4 → crossing at sample 20 (addr 2) is ignored in PRE. A falling-level test with trig_rising=0 fires on the first downward crossing.
- PTR_BITS=4, pre_count=15, post_count=8, sw_trig after 30 samples → trig_ptr=(30 mod 16)=14, last write at addr 6, wrapped=1, start_ptr=7.
- sw_trig with pre_count=8 after 2 samples → trigger on sample 3 (addr 2). With post_count=0, done asserts with that write.
- arm pulse during POST → restart: wr_ptr=0, done=0, busy=1, the old trig_ptr is retained until the next trigger. Samples arriving in DONE produce no ram_we.

Source files
------------

// File: rtl/adc_capture_ctrl.sv
// Triggered capture controller: streams samples into a circular RAM with pre/post
// trigger depth, then freezes and reports trigger and oldest-sample addresses.
module adc_capture_ctrl #(
   parameter int SAMPLE_WIDTH = 16,
   parameter int PTR_BITS     = 11
) (
   input  logic                    wb_clk_i,
   input  logic                    wb_rst_i,
   input  logic                    s_valid,
   input  logic [SAMPLE_WIDTH-1:0] s_data,
   input  logic                    arm,
   input  logic                    sw_trig,
   input  logic                    trig_en,
   input  logic                    trig_rising,
   input  logic [SAMPLE_WIDTH-1:0] trig_level,
   input  logic [PTR_BITS-1:0]     pre_count,
   input  logic [PTR_BITS-1:0]     post_count,
   output logic                    ram_we,
   output logic [PTR_BITS-1:0]     ram_addr,
   output logic [SAMPLE_WIDTH-1:0] ram_data,
   output logic                    busy,
   output logic                    done,
   output logic                    wrapped,
   output logic [PTR_BITS-1:0]     trig_ptr,
   output logic [PTR_BITS-1:0]     start_ptr
);
   localparam logic [PTR_BITS:0]   DEPTH_CNT = {1'b1, {PTR_BITS{1'b0}}};
   localparam logic [PTR_BITS-1:0] PTR_ONE   = {{(PTR_BITS-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {ST_IDLE, ST_PRE, ST_ARMED, ST_POST, ST_DONE} state_t;
   state_t state_reg, state_next;

   logic [PTR_BITS-1:0]            wr_ptr_reg, pre_cnt_reg, post_cnt_reg, post_left_reg;
   logic [PTR_BITS:0]              wr_count_reg, wr_count_next;
   logic                           prev_valid_reg, sw_pend_reg;
   logic signed [SAMPLE_WIDTH-1:0] prev_data_reg, cur_s, lvl_s;
   logic                           in_capture, can_trig, accept, level_hit, fire, full_next;

   assign cur_s      = $signed(s_data);
   assign lvl_s      = $signed(trig_level);
   assign in_capture = (state_reg == ST_PRE) || (state_reg == ST_ARMED) || (state_reg == ST_POST);
   assign can_trig   = (state_reg == ST_PRE) || (state_reg == ST_ARMED);
   // arm takes priority over a coincident sample, which is dropped
   assign accept     = s_valid && !arm && in_capture;

   // written count saturates at DEPTH so wrapped stays meaningful for long captures
   assign wr_count_next = (wr_count_reg == DEPTH_CNT) ? wr_count_reg : wr_count_reg + 1'b1;
   assign full_next     = (wr_count_next == DEPTH_CNT);

   always_comb begin
      level_hit = 1'b0;
      if (state_reg == ST_ARMED && trig_en && prev_valid_reg) begin
         if (trig_rising)
            level_hit = (prev_data_reg < lvl_s) && (cur_s >= lvl_s);
         else
            level_hit = (prev_data_reg > lvl_s) && (cur_s <= lvl_s);
      end
   end

   assign fire = accept && can_trig && (sw_pend_reg || level_hit);

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i)
         state_reg <= ST_IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      if (arm) begin
         state_next = (pre_count == '0) ? ST_ARMED : ST_PRE;
      end else if (accept) begin
         case (state_reg)
            ST_PRE, ST_ARMED: begin
               if (fire)
                  state_next = (post_cnt_reg == '0) ? ST_DONE : ST_POST;
               else if (state_reg == ST_PRE && wr_count_next >= {1'b0, pre_cnt_reg})
                  state_next = ST_ARMED;
            end
            ST_POST: begin
               if (post_left_reg == PTR_ONE)
                  state_next = ST_DONE;
            end
            default: state_next = state_reg;
         endcase
      end
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_reg)
         ST_PRE, ST_ARMED, ST_POST: busy = 1'b1;
         ST_DONE:                   done = 1'b1;
         default:                   busy = 1'b0;
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         ram_we         <= 1'b0;
         ram_addr       <= '0;
         ram_data       <= '0;
         wrapped        <= 1'b0;
         trig_ptr       <= '0;
         start_ptr      <= '0;
         wr_ptr_reg     <= '0;
         wr_count_reg   <= '0;
         pre_cnt_reg    <= '0;
         post_cnt_reg   <= '0;
         post_left_reg  <= '0;
         prev_valid_reg <= 1'b0;
         prev_data_reg  <= '0;
         sw_pend_reg    <= 1'b0;
      end else begin
         ram_we <= accept;
         if (accept) begin
            ram_addr <= wr_ptr_reg;
            ram_data <= s_data;
         end
         if (arm) begin
            pre_cnt_reg    <= pre_count;
            post_cnt_reg   <= post_count;
            wr_ptr_reg     <= '0;
            wr_count_reg   <= '0;
            wrapped        <= 1'b0;
            prev_valid_reg <= 1'b0;
            sw_pend_reg    <= 1'b0;
         end else begin
            if (fire)
               sw_pend_reg <= 1'b0;
            else if (sw_trig && can_trig)
               sw_pend_reg <= 1'b1;
            if (accept) begin
               wr_ptr_reg     <= wr_ptr_reg + 1'b1;
               wr_count_reg   <= wr_count_next;
               prev_data_reg  <= cur_s;
               prev_valid_reg <= 1'b1;
               if (full_next)
                  wrapped <= 1'b1;
            end
            if (fire) begin
               trig_ptr      <= wr_ptr_reg;
               post_left_reg <= post_cnt_reg;
            end else if (accept && state_reg == ST_POST) begin
               post_left_reg <= post_left_reg - 1'b1;
            end
            // oldest valid sample is the next write slot once the buffer has wrapped
            if (accept && state_next == ST_DONE)
               start_ptr <= (wrapped || full_next) ? wr_ptr_reg + 1'b1 : '0;
         end
      end
   end
endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Scoreboard bench for adc_capture_ctrl: stimulus queues expected RAM writes,
// a forked monitor pops and compares them whenever ram_we is seen.
module tb_adc_capture_ctrl;
   localparam int SW = 16;
   localparam int PB = 4;

   logic          clk, rst;
   logic          s_valid, arm, sw_trig, trig_en, trig_rising;
   logic [SW-1:0] s_data, trig_level;
   logic [PB-1:0] pre_count, post_count;
   logic          ram_we, busy, done, wrapped;
   logic [PB-1:0] ram_addr, trig_ptr, start_ptr;
   logic [SW-1:0] ram_data;

   typedef struct packed {
      logic [PB-1:0] addr;
      logic [SW-1:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   total;
   int   bad;

   adc_capture_ctrl #(.SAMPLE_WIDTH(SW), .PTR_BITS(PB)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .s_valid(s_valid), .s_data(s_data),
      .arm(arm), .sw_trig(sw_trig),
      .trig_en(trig_en), .trig_rising(trig_rising), .trig_level(trig_level),
      .pre_count(pre_count), .post_count(post_count),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data),
      .busy(busy), .done(done), .wrapped(wrapped),
      .trig_ptr(trig_ptr), .start_ptr(start_ptr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
      end else begin
         $display("ok   %s = %0d", name, act);
      end
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (ram_we === 1'b1) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_write actual_addr=%0d actual_data=%0d required=no write t=%0t",
                        ram_addr, ram_data, $time);
            end else begin
               e = exp_q.pop_front();
               check("write_addr", 32'(ram_addr), 32'(e.addr));
               check("write_data", 32'(ram_data), 32'(e.data));
            end
         end
      end
   endtask

   // one cycle with a sample; push an expected write when the sample should be stored
   task automatic send(input int v, input bit exp_wr, input int a);
      exp_t e;
      logic [31:0] vv;
      logic [31:0] aa;
      vv = v;
      aa = a;
      if (exp_wr) begin
         e.addr = aa[PB-1:0];
         e.data = vv[SW-1:0];
         exp_q.push_back(e);
      end
      s_valid = 1'b1;
      s_data  = vv[SW-1:0];
      @(posedge clk);
      #1;
      s_valid = 1'b0;
   endtask

   task automatic do_arm(input int pre, input int post);
      logic [31:0] p0;
      logic [31:0] p1;
      p0 = pre;
      p1 = post;
      pre_count  = p0[PB-1:0];
      post_count = p1[PB-1:0];
      arm = 1'b1;
      @(posedge clk);
      #1;
      arm = 1'b0;
   endtask

   task automatic pulse_sw();
      sw_trig = 1'b1;
      @(posedge clk);
      #1;
      sw_trig = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_level(input bit en, input bit rising, input int lvl);
      logic [31:0] l;
      l = lvl;
      trig_en     = en;
      trig_rising = rising;
      trig_level  = l[SW-1:0];
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst = 1'b1;
      s_valid = 1'b0; s_data = '0; arm = 1'b0; sw_trig = 1'b0;
      trig_en = 1'b0; trig_rising = 1'b1; trig_level = '0;
      pre_count = '0; post_count = '0;
      fork
         monitor();
      join_none

      // streaming ramp held in reset: nothing may be written
      for (int i = 0; i < 4; i++) send(i, 1'b0, 0);
      check("rst_ram_we", 32'(ram_we), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_wrapped", 32'(wrapped), 0);
      check("rst_trig_ptr", 32'(trig_ptr), 0);
      check("rst_start_ptr", 32'(start_ptr), 0);
      check("rst_ram_addr", 32'(ram_addr), 0);
      check("rst_ram_data", 32'(ram_data), 0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) send(50 + i, 1'b0, 0);
      check("idle_busy", 32'(busy), 0);

      // asynchronous reset mid-capture drops ram_we at once
      do_arm(4, 3);
      send(0, 1'b1, 0);
      s_valid = 1'b1; s_data = 16'd1;
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      check("pre_reset_we", 32'(ram_we), 1);
      rst = 1'b1;
      #1;
      check("async_rst_we", 32'(ram_we), 0);
      check("async_rst_busy", 32'(busy), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // rising level trigger at 100 on a ramp of step 10
      set_level(1'b1, 1'b1, 100);
      do_arm(4, 3);
      for (int k = 0; k < 16; k++) begin
         send(k * 10, k <= 13, k);
         if (k == 10) check("t1_trig_ptr_timing", 32'(trig_ptr), 10);
         if (k == 12) check("t1_done_early", 32'(done), 0);
         if (k == 13) begin
            check("t1_done_with_write", 32'(done), 1);
            check("t1_last_we", 32'(ram_we), 1);
         end
      end
      check("t1_trig_ptr", 32'(trig_ptr), 10);
      check("t1_busy", 32'(busy), 0);
      check("t1_wrapped", 32'(wrapped), 0);
      check("t1_start_ptr", 32'(start_ptr), 0);

      // crossing at 20 falls inside the pre-trigger window and is ignored
      set_level(1'b1, 1'b1, 20);
      do_arm(4, 3);
      for (int k = 0; k < 8; k++) send(k * 10, 1'b1, k);
      check("t2_busy", 32'(busy), 1);
      check("t2_done", 32'(done), 0);
      check("t2_trig_kept", 32'(trig_ptr), 10);

      // falling trigger at 25: fires on 30 -> 20, not on the upward pass
      set_level(1'b1, 1'b0, 25);
      do_arm(2, 2);
      begin
         int fv[9] = '{0, 10, 20, 30, 40, 30, 20, 10, 0};
         for (int k = 0; k < 9; k++) send(fv[k], 1'b1, k);
      end
      send(5, 1'b0, 0);
      check("t3_trig_ptr", 32'(trig_ptr), 6);
      check("t3_done", 32'(done), 1);

      // wrap: pre 15, post 8, sw trigger after 30 samples
      set_level(1'b0, 1'b1, 0);
      do_arm(15, 8);
      for (int i = 0; i < 30; i++) send(1000 + i, 1'b1, i % 16);
      check("t4_wrapped_pre", 32'(wrapped), 1);
      pulse_sw();
      for (int i = 30; i < 39; i++) send(1000 + i, 1'b1, i % 16);
      send(2000, 1'b0, 0);
      check("t4_trig_ptr", 32'(trig_ptr), 14);
      check("t4_wrapped", 32'(wrapped), 1);
      check("t4_start_ptr", 32'(start_ptr), 7);
      check("t4_done", 32'(done), 1);

      // sw trigger bypasses pre_count; post_count 0 finishes on the trigger write
      do_arm(8, 0);
      send(500, 1'b1, 0);
      send(501, 1'b1, 1);
      pulse_sw();
      send(502, 1'b1, 2);
      check("t5_done_with_write", 32'(done), 1);
      check("t5_we", 32'(ram_we), 1);
      send(503, 1'b0, 0);
      check("t5_trig_ptr", 32'(trig_ptr), 2);
      check("t5_start_ptr", 32'(start_ptr), 0);
      check("t5_wrapped", 32'(wrapped), 0);

      // arm during POST restarts; coincident sample and sw_trig are dropped
      do_arm(2, 5);
      send(600, 1'b1, 0);
      send(601, 1'b1, 1);
      send(602, 1'b1, 2);
      pulse_sw();
      send(603, 1'b1, 3);
      send(604, 1'b1, 4);
      check("t6_trig_ptr", 32'(trig_ptr), 3);
      s_valid = 1'b1; s_data = 16'd999; sw_trig = 1'b1;
      do_arm(3, 2);
      s_valid = 1'b0; sw_trig = 1'b0;
      check("t6_restart_busy", 32'(busy), 1);
      check("t6_restart_done", 32'(done), 0);
      check("t6_trig_retained", 32'(trig_ptr), 3);
      send(7, 1'b1, 0);
      send(-50, 1'b1, 1);
      check("t6_sw_dropped", 32'(trig_ptr), 3);

      // pre_count 0: first sample never level-fires; signed crossing of 0
      set_level(1'b1, 1'b1, 0);
      do_arm(0, 1);
      send(20, 1'b1, 0);
      send(-30, 1'b1, 1);
      check("t7_no_first_fire", 32'(trig_ptr), 3);
      send(40, 1'b1, 2);
      send(7, 1'b1, 3);
      check("t7_trig_ptr", 32'(trig_ptr), 2);
      check("t7_done", 32'(done), 1);
      check("t7_start_ptr", 32'(start_ptr), 0);

      idle(3);
      check("queue_drained", 32'(exp_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end
endmodule
